rob_ring: RTL

Parametrised circular reorder buffer that succeeds the fixed 10-entry shift-queue ROB. It allocates tags in program order from the decoder, accepts results from `CDB_N` write-back channels in the same cycle, and commits in order from the head to the register file / store buffer. Mispredicted branches are resolved at commit by a single-cycle flush. It sits between instruction decode/dispatch and regfile/slb/pc.

---
 rtl/rob_pkg.sv | 34 +++
 rtl/rob_cdb_match.sv | 53 +++++
 rtl/rob_ring.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the circular reorder buffer (rob_ring):
//   - destination-type encodings carried with every entry
//   - the per-entry storage record
//   - the tag width helper used to size tags and pointers
// No ports; imported by rob_ring and rob_cdb_match.
// -----------------------------------------------------------------------------
package rob_pkg;

    typedef enum logic [1:0] {
        DT_STORE  = 2'd0,
        DT_REG    = 2'd1,
        DT_BRANCH = 2'd2,
        DT_JL     = 2'd3
    } dest_type_e;

    typedef struct packed {
        logic        valid;
        logic        done;
        dest_type_e  dtype;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] value;
        logic        pred_taken;
        logic        mispredict;
        logic [31:0] target;
    } rob_entry_t;

    function automatic int tag_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/rob_cdb_match.sv
// -----------------------------------------------------------------------------
// rob_cdb_match
// Priority match of one ROB entry tag against all CDB write-back channels.
// When several channels carry the same tag, the lowest channel index wins.
//
// Ports:
//   entry_tag   in  TAG_W       tag of the entry this instance watches
//   cdb_valid   in  CDB_N       per-channel write-back strobe
//   cdb_tag     in  CDB_N*TAG_W packed channel tags, channel 0 in LSBs
//   cdb_value   in  CDB_N*32    packed channel results
//   cdb_taken   in  CDB_N       per-channel actual branch outcome
//   cdb_target  in  CDB_N*32    packed channel taken targets
//   hit         out 1           some valid channel carries entry_tag
//   value       out 32          result from the winning channel
//   taken       out 1           branch outcome from the winning channel
//   target      out 32          target from the winning channel
// -----------------------------------------------------------------------------
module rob_cdb_match
    import rob_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CDB_N = 3
) (
    input  logic [TAG_W-1:0]       entry_tag,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag,
    input  logic [CDB_N*32-1:0]    cdb_value,
    input  logic [CDB_N-1:0]       cdb_taken,
    input  logic [CDB_N*32-1:0]    cdb_target,
    output logic                   hit,
    output logic [31:0]            value,
    output logic                   taken,
    output logic [31:0]            target
);

    // Scan from the highest channel down so the lowest matching index is
    // the last assignment and therefore wins.
    always_comb begin
        hit    = 1'b0;
        value  = 32'd0;
        taken  = 1'b0;
        target = 32'd0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == entry_tag)) begin
                hit    = 1'b1;
                value  = cdb_value[c*32 +: 32];
                taken  = cdb_taken[c];
                target = cdb_target[c*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/rob_ring.sv
// -----------------------------------------------------------------------------
// rob_ring
// Circular reorder buffer. Allocates tags in program order at dispatch,
// completes entries from CDB_N write-back channels, retires in order from the
// head, and issues a one-cycle redirect (flush) when a mispredicted branch or
// a jump-and-link entry commits.
//
// Parameters: DEPTH (power of two, >= 4), CDB_N; TAG_W is derived.
//
// Ports:
//   clk_in, rst_n_in              clock, async active-low reset
//   rdy_in                        global ready; low freezes all state
//   disp_*                        dispatch request / entry fields / allocated tag
//   cdb_*                         packed write-back channels (channel 0 in LSBs)
//   commit_*                      head entry, combinational from head registers
//   flush_out, flush_pc_out       registered one-cycle redirect
//   count_out, empty_out, full_out occupancy from the pointers
//
// Optional build macro ROB_OPERAND_QUERY_EN adds two operand lookup ports
// (q_tag_in / q_done_out / q_value_out) with same-cycle CDB forwarding.
// -----------------------------------------------------------------------------
module rob_ring
    import rob_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CDB_N = 3,
    localparam int TAG_W = tag_width(DEPTH)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,

    input  logic                   disp_valid_in,
    output logic                   disp_ready_out,
    input  logic [1:0]             disp_type_in,
    input  logic [4:0]             disp_rd_in,
    input  logic [31:0]            disp_pc_in,
    input  logic                   disp_pred_taken_in,
    input  logic                   disp_done_in,
    input  logic [31:0]            disp_value_in,
    output logic [TAG_W-1:0]       disp_tag_out,

    input  logic [CDB_N-1:0]       cdb_valid_in,
    input  logic [CDB_N*TAG_W-1:0] cdb_tag_in,
    input  logic [CDB_N*32-1:0]    cdb_value_in,
    input  logic [CDB_N-1:0]       cdb_taken_in,
    input  logic [CDB_N*32-1:0]    cdb_target_in,

    output logic                   commit_valid_out,
    input  logic                   commit_ready_in,
    output logic [TAG_W-1:0]       commit_tag_out,
    output logic [1:0]             commit_type_out,
    output logic [4:0]             commit_rd_out,
    output logic [31:0]            commit_value_out,

    output logic                   flush_out,
    output logic [31:0]            flush_pc_out,

    output logic [TAG_W:0]         count_out,
    output logic                   empty_out,
    output logic                   full_out
`ifdef ROB_OPERAND_QUERY_EN
    ,
    input  logic [TAG_W-1:0]       q_tag_in    [2],
    output logic                   q_done_out  [2],
    output logic [31:0]            q_value_out [2]
`endif
);

    localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

    rob_entry_t         ent [DEPTH];
    logic [TAG_W:0]     head;
    logic [TAG_W:0]     tail;
    logic [TAG_W-1:0]   head_idx;
    logic [TAG_W-1:0]   tail_idx;
    logic               flush_r;
    logic [31:0]        flush_pc_r;

    rob_entry_t         head_ent;
    logic               commit_fire;
    logic               disp_fire;
    logic               needs_flush;
    logic [31:0]        redirect_pc;
    logic               cdb_accept;

    logic [DEPTH-1:0]   m_hit;
    logic [31:0]        m_value  [DEPTH];
    logic [DEPTH-1:0]   m_taken;
    logic [31:0]        m_target [DEPTH];
    logic [DEPTH-1:0]   cdb_we;

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];

    // Extra wrap bit distinguishes full (same index, different lap) from empty.
    assign full_out  = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign empty_out = (head == tail);
    assign count_out = tail - head;

    assign flush_out    = flush_r;
    assign flush_pc_out = flush_pc_r;

    assign disp_ready_out = !full_out && rdy_in && !flush_r;
    assign disp_fire      = disp_valid_in && disp_ready_out;
    assign disp_tag_out   = tail_idx;

    assign head_ent         = ent[head_idx];
    assign commit_valid_out = head_ent.valid && head_ent.done && rdy_in;
    assign commit_fire      = commit_valid_out && commit_ready_in;
    assign commit_tag_out   = head_idx;
    assign commit_type_out  = head_ent.dtype;
    assign commit_rd_out    = head_ent.rd;
    assign commit_value_out = head_ent.value;

    assign needs_flush = (head_ent.dtype == DT_JL) ||
                         ((head_ent.dtype == DT_BRANCH) && head_ent.mispredict);

    // A mispredicted branch went the opposite way of its prediction, so the
    // actual direction is simply !pred_taken.
    always_comb begin
        redirect_pc = head_ent.pc + 32'd4;
        if (head_ent.dtype == DT_JL) begin
            redirect_pc = head_ent.target;
        end else if (!head_ent.pred_taken) begin
            redirect_pc = head_ent.target;
        end
    end

    // Write-backs are dropped while frozen and during the flush pulse.
    assign cdb_accept = rdy_in && !flush_r;

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        rob_cdb_match #(
            .TAG_W (TAG_W),
            .CDB_N (CDB_N)
        ) u_match (
            .entry_tag  (TAG_W'(g)),
            .cdb_valid  (cdb_valid_in),
            .cdb_tag    (cdb_tag_in),
            .cdb_value  (cdb_value_in),
            .cdb_taken  (cdb_taken_in),
            .cdb_target (cdb_target_in),
            .hit        (m_hit[g]),
            .value      (m_value[g]),
            .taken      (m_taken[g]),
            .target     (m_target[g])
        );

        assign cdb_we[g] = m_hit[g] && ent[g].valid && !ent[g].done && cdb_accept;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head       <= '0;
            tail       <= '0;
            flush_r    <= 1'b0;
            flush_pc_r <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else if (rdy_in) begin
            flush_r <= commit_fire && needs_flush;

            if (commit_fire && needs_flush) begin
                // Everything younger than the redirecting entry is wrong-path.
                flush_pc_r <= redirect_pc;
                head       <= '0;
                tail       <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    ent[i].valid <= 1'b0;
                end
            end else begin
                if (commit_fire) begin
                    ent[head_idx].valid <= 1'b0;
                    head                <= head + PTR_ONE;
                end

                // Dispatch never lands on an in-flight entry: the tail slot is
                // invalid unless the buffer is full, and then dispatch is held.
                if (disp_fire) begin
                    ent[tail_idx] <= '{
                        valid:      1'b1,
                        done:       disp_done_in,
                        dtype:      dest_type_e'(disp_type_in),
                        rd:         disp_rd_in,
                        pc:         disp_pc_in,
                        value:      disp_value_in,
                        pred_taken: disp_pred_taken_in,
                        mispredict: 1'b0,
                        target:     32'd0
                    };
                    tail <= tail + PTR_ONE;
                end

                for (int i = 0; i < DEPTH; i++) begin
                    if (cdb_we[i]) begin
                        ent[i].done  <= 1'b1;
                        ent[i].value <= m_value[i];
                        if (ent[i].dtype == DT_BRANCH) begin
                            ent[i].mispredict <= (m_taken[i] != ent[i].pred_taken);
                            ent[i].target     <= m_target[i];
                        end else if (ent[i].dtype == DT_JL) begin
                            ent[i].target <= m_target[i];
                        end
                    end
                end
            end
        end
    end

`ifdef ROB_OPERAND_QUERY_EN
    // Rename bypass: a write-back landing this cycle is visible immediately.
    always_comb begin
        for (int q = 0; q < 2; q++) begin
            q_done_out[q]  = ent[q_tag_in[q]].done || cdb_we[q_tag_in[q]];
            q_value_out[q] = cdb_we[q_tag_in[q]] ? m_value[q_tag_in[q]]
                                                 : ent[q_tag_in[q]].value;
        end
    end
`endif

endmodule
